// File: rtl/video_text_px.sv
// video_text_px: 80x25-style text-mode pixel generator.
// Produces hs/vs sync, a registered 4:4:4 colour stream and the text/font
// memory addresses needed to render a character cell buffer with attributes,
// hardware scrolling, a flashing cursor, blink/bright-background modes and a
// writable 16-entry palette.
// Ports:
//   clock, reset_n              pixel clock, asynchronous active-low reset
//   r, g, b                     registered colour outputs (4 bits each)
//   hs, vs                      sync outputs, polarity set by HS_POL/VS_POL
//   char_address, char_data     text buffer byte address / read data (1-clock latency)
//   font_address, font_data     {code, scanline} / glyph row, bit 7 leftmost
//   start_addr                  cell index shown at the top-left (scroll)
//   cursor, cursor_en           cursor cell index and enable
//   cur_start, cur_end          cursor scanline range, inclusive
//   blink_en                    attr bit 7 selects blink (1) or bright background (0)
//   pal_we, pal_idx, pal_data   palette write port
//   frame_start, vblank         frame pulse at x=0,y=0 and vertical blank level
module video_text_px #(
    parameter int          H_VISIBLE = 640,
    parameter int          H_FRONT   = 16,
    parameter int          H_SYNC    = 96,
    parameter int          H_BACK    = 48,
    parameter int          V_VISIBLE = 400,
    parameter int          V_FRONT   = 12,
    parameter int          V_SYNC    = 2,
    parameter int          V_BACK    = 35,
    parameter bit          HS_POL    = 1'b0,
    parameter bit          VS_POL    = 1'b1,
    parameter int          COLS      = 80,
    parameter int          ROWS      = 25,
    parameter int          FONT_H    = 16,
    parameter logic [17:0] TEXT_BASE = 18'h0F000,
    parameter int          BLINK_DIV = 12500000
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic [3:0]  r,
    output logic [3:0]  g,
    output logic [3:0]  b,
    output logic        hs,
    output logic        vs,
    output logic [17:0] char_address,
    input  logic [7:0]  char_data,
    output logic [11:0] font_address,
    input  logic [7:0]  font_data,
    input  logic [11:0] start_addr,
    input  logic [11:0] cursor,
    input  logic        cursor_en,
    input  logic [3:0]  cur_start,
    input  logic [3:0]  cur_end,
    input  logic        blink_en,
    input  logic        pal_we,
    input  logic [3:0]  pal_idx,
    input  logic [11:0] pal_data,
    output logic        frame_start,
    output logic        vblank
);

    localparam logic [11:0] H_LAST       = 12'(H_BACK + H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [11:0] V_LAST       = 12'(V_BACK + V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [11:0] H_VIS_START  = 12'(H_BACK);
    localparam logic [11:0] H_VIS_END    = 12'(H_BACK + H_VISIBLE);
    localparam logic [11:0] H_SYNC_START = 12'(H_BACK + H_VISIBLE + H_FRONT);
    localparam logic [11:0] V_VIS_START  = 12'(V_BACK);
    localparam logic [11:0] V_VIS_END    = 12'(V_BACK + V_VISIBLE);
    localparam logic [11:0] V_SYNC_START = 12'(V_BACK + V_VISIBLE + V_FRONT);
    localparam logic [31:0] BLINK_LAST   = 32'(BLINK_DIV - 1);

    logic [11:0] x_r, y_r;
    logic [31:0] timer_r;
    logic        flash_r;
    logic [7:0]  attr_r, pattern_r;
    logic        cur_hit_r, out_r;
    logic [11:0] rgb_r;
    logic [11:0] pal_r [16];

    logic [11:0] fx_s, fy_s, col_s, row_s, id_s, word_s;
    logic [3:0]  line_s;
    logic [17:0] char_addr_s, attr_addr_s;
    logic        out_s, cur_ok_s, vis_s, bit_s;
    logic [3:0]  fg_s, bg_s, idx_s;
    logic [11:0] color_s;

    function automatic logic [11:0] pal_default(input logic [3:0] i);
        case (i)
            4'd0:    pal_default = 12'h111;
            4'd1:    pal_default = 12'h008;
            4'd2:    pal_default = 12'h080;
            4'd3:    pal_default = 12'h088;
            4'd4:    pal_default = 12'h800;
            4'd5:    pal_default = 12'h808;
            4'd6:    pal_default = 12'h880;
            4'd7:    pal_default = 12'hCCC;
            4'd8:    pal_default = 12'h888;
            4'd9:    pal_default = 12'h00F;
            4'd10:   pal_default = 12'h0F0;
            4'd11:   pal_default = 12'h0FF;
            4'd12:   pal_default = 12'hF00;
            4'd13:   pal_default = 12'hF0F;
            4'd14:   pal_default = 12'hFF0;
            default: pal_default = 12'hFFF;
        endcase
    endfunction

    // Fetch coordinates run one cell (8 pixels) ahead of the displayed pixel;
    // off-window values wrap to huge col/row and are flagged as out-of-range.
    always_comb begin
        fx_s        = x_r - H_VIS_START + 12'd8;
        fy_s        = y_r - V_VIS_START;
        col_s       = {3'b000, fx_s[11:3]};
        if (FONT_H == 16) begin
            row_s  = {4'b0000, fy_s[11:4]};
            line_s = fy_s[3:0];
        end else begin
            row_s  = {3'b000, fy_s[11:3]};
            line_s = {1'b0, fy_s[2:0]};
        end
        id_s        = col_s + row_s * 12'(COLS);
        word_s      = start_addr + id_s;
        char_addr_s = TEXT_BASE + {5'b00000, word_s, 1'b0};
        attr_addr_s = char_addr_s + 18'd1;
        out_s       = (col_s >= 12'(COLS)) || (row_s >= 12'(ROWS));
        cur_ok_s    = cursor_en && (id_s == cursor) && (cur_start <= line_s) && (line_s <= cur_end);
    end

    // Pixel evaluation: glyph bit plus cursor, attribute decode, palette lookup.
    always_comb begin
        vis_s = (x_r >= H_VIS_START) && (x_r < H_VIS_END) &&
                (y_r >= V_VIS_START) && (y_r < V_VIS_END);
        bit_s = pattern_r[3'd7 - fx_s[2:0]] | (cur_hit_r & flash_r);
        if (blink_en) begin
            bg_s = {1'b0, attr_r[6:4]};
            if (attr_r[7] && flash_r) begin
                fg_s = bg_s;
            end else begin
                fg_s = attr_r[3:0];
            end
        end else begin
            bg_s = attr_r[7:4];
            fg_s = attr_r[3:0];
        end
        if (out_r) begin
            idx_s = 4'd0;
        end else if (bit_s) begin
            idx_s = fg_s;
        end else begin
            idx_s = bg_s;
        end
        if (vis_s) begin
            color_s = pal_r[idx_s];
        end else begin
            color_s = 12'h000;
        end
    end

    // Raster counters and registered sync/blank/frame outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_r         <= 12'd0;
            y_r         <= 12'd0;
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            frame_start <= 1'b0;
            vblank      <= 1'b1;
        end else begin
            if (x_r == H_LAST) begin
                x_r <= 12'd0;
                y_r <= (y_r == V_LAST) ? 12'd0 : y_r + 12'd1;
            end else begin
                x_r <= x_r + 12'd1;
            end
            hs          <= (x_r >= H_SYNC_START) ? HS_POL : ~HS_POL;
            vs          <= (y_r >= V_SYNC_START) ? VS_POL : ~VS_POL;
            frame_start <= (x_r == 12'd0) && (y_r == 12'd0);
            vblank      <= (y_r < V_VIS_START) || (y_r >= V_VIS_END);
        end
    end

    // Flash timer for cursor and blinking attributes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timer_r <= 32'd0;
            flash_r <= 1'b0;
        end else if (timer_r == BLINK_LAST) begin
            timer_r <= 32'd0;
            flash_r <= ~flash_r;
        end else begin
            timer_r <= timer_r + 32'd1;
        end
    end

    // Per-cell fetch sequence keyed on the pixel phase within the fetched cell.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            char_address <= 18'd0;
            font_address <= 12'd0;
            attr_r       <= 8'd0;
            pattern_r    <= 8'd0;
            cur_hit_r    <= 1'b0;
            out_r        <= 1'b0;
        end else begin
            case (fx_s[2:0])
                3'd0: char_address <= char_addr_s;
                3'd2: font_address <= {char_data, line_s};
                3'd4: char_address <= attr_addr_s;
                3'd7: begin
                    attr_r    <= char_data;
                    pattern_r <= font_data;
                    cur_hit_r <= cur_ok_s;
                    out_r     <= out_s;
                end
                default: begin
                end
            endcase
        end
    end

    // Palette storage; a same-cycle read sees the value before the write.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                pal_r[i] <= pal_default(4'(i));
            end
        end else if (pal_we) begin
            pal_r[pal_idx] <= pal_data;
        end
    end

    // Registered colour output.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rgb_r <= 12'h000;
        end else begin
            rgb_r <= color_s;
        end
    end

    assign r = rgb_r[11:8];
    assign g = rgb_r[7:4];
    assign b = rgb_r[3:0];

endmodule

// File: tb/tb_video_text_px.sv
// Directed bench for video_text_px using a shrunken raster:
// 60 clocks per line (back 16, visible 32, front 4, sync 8), 48 lines per
// frame (back 4, visible 40, front 2, sync 2), 3x2 text cells of 8x16, and a
// flash period of exactly one frame so odd frames have flash=1.
// Outputs reflect the raster position one clock earlier, so the pixel at
// position p (counted in clocks since reset release) is sampled after p+1 edges.
module tb_video_text_px;

    logic        clock;
    logic        reset_n;
    logic [3:0]  r, g, b;
    logic        hs, vs;
    logic [17:0] char_address;
    logic [7:0]  char_data;
    logic [11:0] font_address;
    logic [7:0]  font_data;
    logic [11:0] start_addr, cursor;
    logic        cursor_en;
    logic [3:0]  cur_start, cur_end;
    logic        blink_en;
    logic        pal_we;
    logic [3:0]  pal_idx;
    logic [11:0] pal_data;
    logic        frame_start, vblank;

    logic [7:0]  tmem [0:262143];
    logic [7:0]  fmem [0:4095];

    int checks;
    int failures;
    int cyc;

    video_text_px #(
        .H_VISIBLE(32), .H_FRONT(4), .H_SYNC(8), .H_BACK(16),
        .V_VISIBLE(40), .V_FRONT(2), .V_SYNC(2), .V_BACK(4),
        .HS_POL(1'b0), .VS_POL(1'b1),
        .COLS(3), .ROWS(2), .FONT_H(16),
        .TEXT_BASE(18'h0F000), .BLINK_DIV(2880)
    ) dut (
        .clock(clock), .reset_n(reset_n),
        .r(r), .g(g), .b(b), .hs(hs), .vs(vs),
        .char_address(char_address), .char_data(char_data),
        .font_address(font_address), .font_data(font_data),
        .start_addr(start_addr), .cursor(cursor), .cursor_en(cursor_en),
        .cur_start(cur_start), .cur_end(cur_end), .blink_en(blink_en),
        .pal_we(pal_we), .pal_idx(pal_idx), .pal_data(pal_data),
        .frame_start(frame_start), .vblank(vblank)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous memories with one clock of read latency.
    always @(posedge clock) begin
        char_data <= tmem[char_address];
        font_data <= fmem[font_address];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance until n edges since reset release, then settle on the falling edge.
    task automatic step_to(input int n);
        while (cyc < n) begin
            @(posedge clock);
            cyc++;
        end
        @(negedge clock);
    endtask

    function automatic logic [31:0] rgb_now();
        return {20'd0, r, g, b};
    endfunction

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        for (int i = 0; i < 262144; i++) tmem[i] = 8'h00;
        for (int i = 0; i < 4096; i++) fmem[i] = 8'h00;
        // cell 0: 'A' white on blue, glyph row 0 = leftmost pixel only
        tmem[18'h0F000] = 8'h41; tmem[18'h0F001] = 8'h1F;
        fmem[12'h410]   = 8'h80;
        // cell 2: blinking/bright attr F1, glyph row 0 solid, row 1 empty
        tmem[18'h0F004] = 8'h20; tmem[18'h0F005] = 8'hF1;
        fmem[12'h200]   = 8'hFF;
        // cell 4 (col 1,row 1): cursor cell, attr 2A, empty glyph
        tmem[18'h0F008] = 8'h42; tmem[18'h0F009] = 8'h2A;

        reset_n = 1'b0;
        start_addr = 12'd0;
        cursor = 12'd4;
        cursor_en = 1'b1;
        cur_start = 4'd14;
        cur_end = 4'd15;
        blink_en = 1'b1;
        pal_we = 1'b0;
        pal_idx = 4'd0;
        pal_data = 12'h000;

        repeat (3) @(negedge clock);
        check_val("rst_rgb", rgb_now(), 32'h0);
        check_val("rst_hs", {31'd0, hs}, 32'd1);
        check_val("rst_vs", {31'd0, vs}, 32'd0);
        check_val("rst_fs", {31'd0, frame_start}, 32'd0);
        check_val("rst_caddr", {14'd0, char_address}, 32'h0);
        check_val("rst_faddr", {20'd0, font_address}, 32'h0);
        reset_n = 1'b1;
        cyc = 0;

        // frame 0, flash = 0
        step_to(1);    check_val("fs_first", {31'd0, frame_start}, 32'd1);
        step_to(2);    check_val("fs_pulse", {31'd0, frame_start}, 32'd0);
        step_to(52);   check_val("hs_x51", {31'd0, hs}, 32'd1);
        step_to(53);   check_val("hs_x52", {31'd0, hs}, 32'd0);
        step_to(61);   check_val("hs_x0", {31'd0, hs}, 32'd1);
                       check_val("vblank_y1", {31'd0, vblank}, 32'd1);
        step_to(256);  check_val("porch_black", rgb_now(), 32'h000);
        step_to(257);  check_val("cell0_px0", rgb_now(), 32'hFFF);
                       check_val("vblank_y4", {31'd0, vblank}, 32'd0);
        step_to(258);  check_val("cell0_px1", rgb_now(), 32'h008);
        step_to(264);  check_val("cell0_px7", rgb_now(), 32'h008);
        step_to(273);  check_val("blink_off_fg", rgb_now(), 32'h008);
        step_to(281);  check_val("col_oob", rgb_now(), 32'h111);
        step_to(288);  check_val("last_vis", rgb_now(), 32'h111);
        step_to(289);  check_val("after_vis", rgb_now(), 32'h000);
        step_to(2177); check_val("row_oob", rgb_now(), 32'h111);
        step_to(2641); check_val("vblank_y44", {31'd0, vblank}, 32'd1);
        step_to(2701); check_val("vs_y45", {31'd0, vs}, 32'd0);
        step_to(2761); check_val("vs_y46", {31'd0, vs}, 32'd1);
        step_to(2881); check_val("fs_frame1", {31'd0, frame_start}, 32'd1);

        // frame 1, flash = 1
        step_to(3153); check_val("blink_on_fg", rgb_now(), 32'hCCC);
        step_to(4888); check_val("cur_line13", rgb_now(), 32'h080);
        step_to(4948); check_val("cur_line14_on", rgb_now(), 32'h0F0);
        blink_en = 1'b0;

        // frame 2, flash = 0
        step_to(6093); check_val("bright_bg", rgb_now(), 32'hFFF);
        step_to(7828); check_val("cur_line14_off", rgb_now(), 32'h080);
        start_addr = 12'd4095;
        cur_start = 4'd15;
        cur_end = 4'd14;

        // frame 3, flash = 1, scrolled by 4095 cells
        step_to(8889); check_val("scroll_col0", {14'd0, char_address}, 32'h10FFE);
        step_to(8897); check_val("scroll_wrap", {14'd0, char_address}, 32'h0F000);
        step_to(8899); check_val("font_addr", {20'd0, font_address}, 32'h410);
        step_to(8901); check_val("attr_addr", {14'd0, char_address}, 32'h0F001);
        start_addr = 12'd0;
        step_to(10708); check_val("cur_empty_range", rgb_now(), 32'h080);

        // frame 4: palette write, same-cycle read sees old entry
        step_to(11800);
        pal_we = 1'b1; pal_idx = 4'd0; pal_data = 12'hABC;
        step_to(11801); check_val("pal_old", rgb_now(), 32'h111);
        pal_we = 1'b0;
        step_to(11802); check_val("pal_new", rgb_now(), 32'hABC);
        step_to(13697); check_val("pal_new_row", rgb_now(), 32'hABC);

        // mid-frame reset restores palette and restarts the frame
        reset_n = 1'b0;
        @(negedge clock);
        check_val("midrst_rgb", rgb_now(), 32'h0);
        check_val("midrst_hs", {31'd0, hs}, 32'd1);
        reset_n = 1'b1;
        cyc = 0;
        step_to(1);   check_val("fs_after_rst", {31'd0, frame_start}, 32'd1);
        step_to(281); check_val("pal_restored", rgb_now(), 32'h111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
